// File: rtl/pbus_fabric_if.sv
`default_nettype none
// ============================================================================
// Module   : pbus_fabric_if
// Purpose  : Bus bundle between the Wishbone master, the peripheral fabric
//            and the peripheral register slots.
// Revision : 1.0 - initial release
// ============================================================================
interface pbus_fabric_if #(
    parameter int NSLOT   = 8,
    parameter int SLOT_AW = 3,
    parameter int AW      = 10,
    parameter int DW      = 8
);
    // Wishbone side
    logic [AW-1:0]       WB_ADRi;
    logic [DW-1:0]       WB_DATi;
    logic                WB_WEi;
    logic                WB_CYCi;
    logic                WB_STBi;
    logic [DW-1:0]       WB_DATo;
    logic                WB_ACKo;
    logic                WB_ERRo;
    // Peripheral slot side
    logic [NSLOT-1:0]    S_STBo;
    logic                S_WEo;
    logic [SLOT_AW-1:0]  S_ADRo;
    logic [DW-1:0]       S_DATo;
    logic [NSLOT*DW-1:0] S_DATi;
    logic [NSLOT-1:0]    S_ACKi;

    // Fabric view
    modport slave (
        input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        output WB_DATo, WB_ACKo, WB_ERRo,
        output S_STBo, S_WEo, S_ADRo, S_DATo,
        input  S_DATi, S_ACKi
    );

    // Environment view (bus master plus peripheral slots)
    modport master (
        output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        input  WB_DATo, WB_ACKo, WB_ERRo,
        input  S_STBo, S_WEo, S_ADRo, S_DATo,
        output S_DATi, S_ACKi
    );
endinterface
`default_nettype wire

// File: rtl/pbus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : pbus_fabric
// Purpose  : Wishbone peripheral-page decoder with per-slot auto/slave ack,
//            bus timeout with error response and a built-in error-status slot.
// Revision : 1.0 - initial release
// ============================================================================
module pbus_fabric #(
    parameter int               NSLOT    = 8,
    parameter int               SLOT_AW  = 3,
    parameter int               AW       = 10,
    parameter int               DW       = 8,
    parameter logic [NSLOT-1:0] ACK_MASK = '0,
    parameter int               TIMEOUT  = 15
) (
    input wire           clk,
    input wire           rst,
    pbus_fabric_if.slave bus
);
    localparam int               c_SW       = $clog2(NSLOT);
    localparam logic [c_SW-1:0]  c_INT_SLOT = c_SW'(NSLOT - 1);
    localparam logic [NSLOT-1:0] c_ONE      = NSLOT'(1);
    localparam logic [7:0]       c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_SW-1:0]      r_slot;
    logic [SLOT_AW-1:0]   r_ofs;
    logic                 r_we;
    logic [DW-1:0]        r_wdat;
    logic [NSLOT-1:0]     r_stb;
    logic [7:0]           r_wait_cnt;
    logic                 r_ack;
    logic                 r_err;
    logic [DW-1:0]        r_rdat;
    logic [7:0]           r_err_cnt;
    logic [c_SW-1:0]      r_err_slot;
    logic [SLOT_AW-1:0]   r_err_ofs;
    logic                 r_err_we;

    logic [c_SW-1:0]      w_req_slot;
    logic                 w_is_int;
    logic                 w_done;
    logic [DW-1:0]        w_int_rdat;
    logic [DW-1:0]        w_sdat [NSLOT];

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slice
        assign w_sdat[gi] = bus.S_DATi[gi*DW +: DW];
    end

    // Address bits above the slot field select nothing inside the page.
    if (AW > c_SW + SLOT_AW) begin : g_adr_hi
        logic w_unused_adr;
        assign w_unused_adr = ^bus.WB_ADRi[AW-1:c_SW+SLOT_AW];
    end

    assign w_req_slot = bus.WB_ADRi[SLOT_AW +: c_SW];
    assign w_is_int   = (r_slot == c_INT_SLOT);
    assign w_done     = w_is_int || !ACK_MASK[r_slot] || bus.S_ACKi[r_slot];

    always_comb begin
        w_int_rdat = '0;
        case (r_ofs)
            SLOT_AW'(0): w_int_rdat[7:0]         = r_err_cnt;
            SLOT_AW'(1): w_int_rdat[c_SW-1:0]    = r_err_slot;
            SLOT_AW'(2): w_int_rdat[SLOT_AW-1:0] = r_err_ofs;
            SLOT_AW'(3): w_int_rdat[0]           = r_err_we;
            default:     w_int_rdat              = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_slot     <= '0;
            r_ofs      <= '0;
            r_we       <= 1'b0;
            r_wdat     <= '0;
            r_stb      <= '0;
            r_wait_cnt <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdat     <= '0;
            r_err_cnt  <= '0;
            r_err_slot <= '0;
            r_err_ofs  <= '0;
            r_err_we   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.WB_CYCi && bus.WB_STBi) begin
                        r_slot     <= w_req_slot;
                        r_ofs      <= bus.WB_ADRi[SLOT_AW-1:0];
                        r_we       <= bus.WB_WEi;
                        r_wdat     <= bus.WB_DATi;
                        r_stb      <= c_ONE << w_req_slot;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Master abandoning the cycle outranks any ack or timeout.
                    if (!bus.WB_CYCi) begin
                        r_stb   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_done) begin
                        r_stb   <= '0;
                        r_ack   <= 1'b1;
                        r_state <= ST_RESP;
                        if (!r_we) begin
                            r_rdat <= w_is_int ? w_int_rdat : w_sdat[r_slot];
                        end else if (w_is_int && r_ofs == '0) begin
                            r_err_cnt <= '0;
                        end
                    end else if (r_wait_cnt == c_TMO_LAST) begin
                        r_stb      <= '0;
                        r_err      <= 1'b1;
                        r_state    <= ST_RESP;
                        r_err_slot <= r_slot;
                        r_err_ofs  <= r_ofs;
                        r_err_we   <= r_we;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_stb   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.WB_DATo = r_rdat;
    assign bus.WB_ACKo = r_ack;
    assign bus.WB_ERRo = r_err;
    assign bus.S_STBo  = r_stb;
    assign bus.S_WEo   = r_we;
    assign bus.S_ADRo  = r_ofs;
    assign bus.S_DATo  = r_wdat;
endmodule
`default_nettype wire

// File: tb/tb_pbus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbus_fabric
// Purpose  : Self-checking bench for pbus_fabric (slot 3 slave-acked).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbus_fabric;
    localparam int               NSLOT    = 8;
    localparam int               SLOT_AW  = 3;
    localparam int               AW       = 10;
    localparam int               DW       = 8;
    localparam int               TIMEOUT  = 15;
    localparam logic [NSLOT-1:0] ACK_MASK = 8'h08;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pbus_fabric_if #(.NSLOT(NSLOT), .SLOT_AW(SLOT_AW), .AW(AW), .DW(DW)) bus ();

    pbus_fabric #(
        .NSLOT(NSLOT), .SLOT_AW(SLOT_AW), .AW(AW), .DW(DW),
        .ACK_MASK(ACK_MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [9:0] adr;
        logic       we;
        logic [7:0] wdat;
        int         ack_at;   // WAIT cycle in which slot acks, 0 = never
        bit         noise;    // drive acks on every other slot
        bit         exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;  // cycles from request edge to response
    } vec_t;

    typedef struct {
        bit         err;
        logic [7:0] dat;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    logic [7:0] model_dat = 8'h00;
    vec_t       vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] adr, input logic we, input logic [7:0] wdat,
                                input int ack_at, input bit noise, input bit err,
                                input logic [7:0] rd, input int lat);
        vec_t v;
        v.adr = adr; v.we = we; v.wdat = wdat; v.ack_at = ack_at; v.noise = noise;
        v.exp_err = err; v.exp_rd = rd; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [29:0] all_outs();
        return {bus.WB_DATo, bus.WB_ACKo, bus.WB_ERRo, bus.S_STBo,
                bus.S_WEo, bus.S_ADRo, bus.S_DATo};
    endfunction

    // Scoreboard consumer: every response must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.WB_ACKo === 1'b1 || bus.WB_ERRo === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, bus.WB_ACKo, bus.WB_ERRo}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_kind", {30'd0, bus.WB_ACKo, bus.WB_ERRo}, {30'd0, !e.err, e.err});
                chk("resp_data", {24'd0, bus.WB_DATo}, {24'd0, e.dat});
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int               cyc;
        bit               got;
        bit               sig_ok;
        logic [NSLOT-1:0] exp_stb;
        exp_stb = 8'b1 << v.adr[5:3];
        if (!v.exp_err && !v.we) model_dat = v.exp_rd;
        sb_q.push_back('{v.exp_err, model_dat});
        bus.WB_ADRi = v.adr;
        bus.WB_WEi  = v.we;
        bus.WB_DATi = v.wdat;
        bus.WB_CYCi = 1'b1;
        bus.WB_STBi = 1'b1;
        bus.S_ACKi  = v.noise ? ~exp_stb : '0;
        cyc = 0; got = 0; sig_ok = 1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.WB_ACKo === 1'b1 || bus.WB_ERRo === 1'b1) begin
                got = 1;
            end else begin
                if (bus.S_STBo !== exp_stb || bus.S_WEo !== v.we ||
                    bus.S_ADRo !== v.adr[2:0] || bus.S_DATo !== v.wdat) sig_ok = 0;
                bus.S_ACKi = v.noise ? ~exp_stb : '0;
                if (v.ack_at != 0 && cyc == v.ack_at) bus.S_ACKi = bus.S_ACKi | exp_stb;
            end
        end
        bus.WB_CYCi = 1'b0;
        bus.WB_STBi = 1'b0;
        bus.S_ACKi  = '0;
        chk($sformatf("latency_adr%0h", v.adr), cyc, v.exp_lat);
        chk($sformatf("wait_sigs_adr%0h", v.adr), {31'd0, sig_ok}, 32'd1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int first;
        int second;
        // Slot read data; slot 7 value must never reach WB_DATo.
        bus.S_DATi  = {8'hEE, 8'h66, 8'h55, 8'h44, 8'h33, 8'hA5, 8'h22, 8'h11};
        bus.S_ACKi  = '0;
        bus.WB_ADRi = '0; bus.WB_DATi = '0; bus.WB_WEi = 1'b0;
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;

        //               adr     we   wdat  ack  nz err rd     lat
        vecs[0]  = mk(10'h038, 1'b0, 8'h00, 0,  0, 0, 8'h00, 2);
        vecs[1]  = mk(10'h011, 1'b0, 8'h00, 0,  0, 0, 8'hA5, 2);
        vecs[2]  = mk(10'h007, 1'b0, 8'h9E, 0,  0, 0, 8'h11, 2);
        vecs[3]  = mk(10'h3E0, 1'b0, 8'h00, 0,  0, 0, 8'h44, 2);
        vecs[4]  = mk(10'h02B, 1'b1, 8'h5A, 0,  0, 0, 8'h00, 2);
        vecs[5]  = mk(10'h01A, 1'b1, 8'h3C, 4,  0, 0, 8'h00, 5);
        vecs[6]  = mk(10'h019, 1'b0, 8'h00, 1,  1, 0, 8'h33, 2);
        vecs[7]  = mk(10'h01D, 1'b0, 8'h00, 0,  1, 1, 8'h00, 16);
        vecs[8]  = mk(10'h038, 1'b0, 8'h00, 0,  0, 0, 8'h01, 2);
        vecs[9]  = mk(10'h039, 1'b0, 8'h00, 0,  0, 0, 8'h03, 2);
        vecs[10] = mk(10'h03A, 1'b0, 8'h00, 0,  0, 0, 8'h05, 2);
        vecs[11] = mk(10'h03B, 1'b0, 8'h00, 0,  0, 0, 8'h00, 2);
        vecs[12] = mk(10'h039, 1'b1, 8'h00, 0,  0, 0, 8'h00, 2);
        vecs[13] = mk(10'h039, 1'b0, 8'h00, 0,  0, 0, 8'h03, 2);
        vecs[14] = mk(10'h01A, 1'b1, 8'h77, 0,  0, 1, 8'h00, 16);
        vecs[15] = mk(10'h03B, 1'b0, 8'h00, 0,  0, 0, 8'h01, 2);
        vecs[16] = mk(10'h03A, 1'b0, 8'h00, 0,  0, 0, 8'h02, 2);
        vecs[17] = mk(10'h038, 1'b0, 8'h00, 0,  0, 0, 8'h02, 2);
        vecs[18] = mk(10'h038, 1'b1, 8'hFF, 0,  0, 0, 8'h00, 2);
        vecs[19] = mk(10'h038, 1'b0, 8'h00, 0,  0, 0, 8'h00, 2);
        vecs[20] = mk(10'h01F, 1'b0, 8'h00, 15, 0, 0, 8'h33, 16);
        vecs[21] = mk(10'h038, 1'b0, 8'h00, 0,  0, 0, 8'h00, 2);
        vecs[22] = mk(10'h03C, 1'b0, 8'h00, 0,  0, 0, 8'h00, 2);
        vecs[23] = mk(10'h034, 1'b0, 8'h00, 0,  0, 0, 8'h66, 2);

        // Reset held with random bus activity.
        repeat (5) begin
            @(negedge clk);
            chk("reset_outputs", {2'd0, all_outs()}, 32'd0);
            bus.WB_ADRi = 10'($urandom);
            bus.WB_WEi  = 1'($urandom);
            bus.WB_DATi = 8'($urandom);
            bus.WB_CYCi = 1'($urandom);
            bus.WB_STBi = 1'($urandom);
            bus.S_ACKi  = 8'($urandom);
        end
        @(negedge clk);
        chk("reset_outputs", {2'd0, all_outs()}, 32'd0);
        bus.WB_ADRi = '0; bus.WB_DATi = '0; bus.WB_WEi = 1'b0;
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0; bus.S_ACKi = '0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) run_txn(vecs[i]);

        // Abort in WAIT cycle 2, with the slave acking at the same moment.
        bus.WB_ADRi = 10'h019; bus.WB_WEi = 1'b0; bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1;
        @(negedge clk);
        chk("abort_stb_wait1", {24'd0, bus.S_STBo}, 32'h08);
        @(negedge clk);
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0; bus.S_ACKi = 8'h08;
        @(negedge clk);
        bus.S_ACKi = '0;
        chk("abort_stb_cleared", {24'd0, bus.S_STBo}, 32'd0);
        chk("abort_no_resp", {30'd0, bus.WB_ACKo, bus.WB_ERRo}, 32'd0);
        run_txn(mk(10'h011, 1'b0, 8'h00, 0, 0, 0, 8'hA5, 2));
        run_txn(mk(10'h038, 1'b0, 8'h00, 0, 0, 0, 8'h00, 2));

        // Master holding STB: one transaction every three cycles.
        sb_q.push_back('{1'b0, 8'h22});
        sb_q.push_back('{1'b0, 8'h22});
        model_dat = 8'h22;
        bus.WB_ADRi = 10'h00A; bus.WB_WEi = 1'b0; bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1;
        first = 0; second = 0;
        for (int c = 1; c <= 10 && second == 0; c++) begin
            @(negedge clk);
            if (bus.WB_ACKo === 1'b1) begin
                if (first == 0) first = c;
                else begin
                    second = c;
                    bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
                end
            end
        end
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
        chk("b2b_first_ack", first, 2);
        chk("b2b_second_ack", second, 5);
        @(negedge clk);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) run_txn(mk(10'h01D, 1'b0, 8'h00, 0, 0, 1, 8'h00, 16));
        run_txn(mk(10'h038, 1'b0, 8'h00, 0, 0, 0, 8'hFF, 2));
        run_txn(mk(10'h039, 1'b0, 8'h00, 0, 0, 0, 8'h03, 2));

        // Asynchronous reset in the middle of a slave-ack transaction.
        bus.WB_ADRi = 10'h019; bus.WB_WEi = 1'b0; bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_stb_before", {24'd0, bus.S_STBo}, 32'h08);
        #1 rst = 1'b0;
        #1 chk("midrst_async_clear", {2'd0, all_outs()}, 32'd0);
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_dat = 8'h00;
        @(negedge clk);
        run_txn(mk(10'h038, 1'b0, 8'h00, 0, 0, 0, 8'h00, 2));
        run_txn(mk(10'h039, 1'b0, 8'h00, 0, 0, 0, 8'h00, 2));

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
